// File: rtl/tactics_turn_ctrl_if.sv
// rtl/tactics_turn_ctrl_if.sv - front-end pulses, unit positions and turn status of the tactics turn controller
interface tactics_turn_ctrl_if #(
  parameter int GRID_W     = 20,
  parameter int GRID_H     = 15,
  parameter int NUM_UNITS  = 2,
  parameter int ANIM_TICKS = 16
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int PW = $clog2(GRID_W * GRID_H);
  localparam int AW = $clog2(ANIM_TICKS + 1);

  logic                    anim_tick;
  logic                    left;
  logic                    right;
  logic                    up;
  logic                    down;
  logic                    sel_pulse;
  logic                    end_pulse;
  logic [NUM_UNITS*PW-1:0] unit_pos;
  logic [XW-1:0]           cursor_x;
  logic [YW-1:0]           cursor_y;
  logic [PW-1:0]           cursor_pos;
  logic [1:0]              phase;
  logic [2:0]              active_unit;
  logic [NUM_UNITS*2-1:0]  unit_state;
  logic [NUM_UNITS-1:0]    spent;
  logic                    enemy_state;
  logic [AW-1:0]           anim_count;
  logic [7:0]              round_count;

  modport master (
    output anim_tick, left, right, up, down, sel_pulse, end_pulse, unit_pos,
    input  cursor_x, cursor_y, cursor_pos, phase, active_unit, unit_state,
           spent, enemy_state, anim_count, round_count
  );

  modport slave (
    input  anim_tick, left, right, up, down, sel_pulse, end_pulse, unit_pos,
    output cursor_x, cursor_y, cursor_pos, phase, active_unit, unit_state,
           spent, enemy_state, anim_count, round_count
  );
endinterface

// File: rtl/tactics_turn_ctrl.sv
// rtl/tactics_turn_ctrl.sv - map cursor, per-unit action FSM, enemy phase and round counter
module tactics_turn_ctrl #(
  parameter int GRID_W      = 20,
  parameter int GRID_H      = 15,
  parameter int NUM_UNITS   = 2,
  parameter int ANIM_TICKS  = 16,
  parameter int CURSOR_X0   = 7,
  parameter int CURSOR_Y0   = 7,
  parameter bit CURSOR_WRAP = 1'b0
) (
  input logic               clk,
  input logic               rst,
  tactics_turn_ctrl_if.slave bus
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int PW = $clog2(GRID_W * GRID_H);
  localparam int AW = $clog2(ANIM_TICKS + 1);

  typedef enum logic [1:0] {
    SELECT    = 2'd0,
    ACTION    = 2'd1,
    UNIT_ANIM = 2'd2,
    ENEMY     = 2'd3
  } phase_t;

  localparam logic [1:0] ST_MOVE   = 2'b00;
  localparam logic [1:0] ST_ATTACK = 2'b01;
  localparam logic [1:0] ST_HIT    = 2'b10;
  localparam logic [1:0] ST_IDLE   = 2'b11;

  phase_t                 phase_q, phase_n;
  logic [XW-1:0]          x_q, x_n;
  logic [YW-1:0]          y_q, y_n;
  logic [2:0]             active_q, active_n;
  logic [NUM_UNITS*2-1:0] ustate_q, ustate_n;
  logic [NUM_UNITS-1:0]   spent_q, spent_n;
  logic                   enemy_q, enemy_n;
  logic [AW-1:0]          anim_q, anim_n;
  logic [7:0]             round_q, round_n;

  logic [PW-1:0]          pos;
  logic                   hit;
  logic [2:0]             hit_idx;
  logic                   finish;
  logic [NUM_UNITS-1:0]   spent_fin;
  logic                   last_tick;

  assign pos       = PW'(y_q) * PW'(GRID_W) + PW'(x_q);
  assign last_tick = bus.anim_tick && (anim_q == AW'(ANIM_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= SELECT;
      x_q      <= XW'(CURSOR_X0);
      y_q      <= YW'(CURSOR_Y0);
      active_q <= '0;
      ustate_q <= '1;
      spent_q  <= '0;
      enemy_q  <= 1'b0;
      anim_q   <= '0;
      round_q  <= '0;
    end else begin
      phase_q  <= phase_n;
      x_q      <= x_n;
      y_q      <= y_n;
      active_q <= active_n;
      ustate_q <= ustate_n;
      spent_q  <= spent_n;
      enemy_q  <= enemy_n;
      anim_q   <= anim_n;
      round_q  <= round_n;
    end
  end

  always_comb begin
    phase_n   = phase_q;
    x_n       = x_q;
    y_n       = y_q;
    active_n  = active_q;
    ustate_n  = ustate_q;
    spent_n   = spent_q;
    enemy_n   = enemy_q;
    anim_n    = anim_q;
    round_n   = round_q;
    hit       = 1'b0;
    hit_idx   = '0;
    finish    = 1'b0;
    spent_fin = spent_q | (NUM_UNITS'(1) << active_q);

    // Descending scan so the lowest-indexed free unit under the cursor wins
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (!spent_q[k] && (bus.unit_pos[k*PW +: PW] == pos)) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end

    if (phase_q == SELECT || phase_q == ACTION) begin
      if (bus.left && !bus.right) begin
        if (x_q == '0) x_n = CURSOR_WRAP ? XW'(GRID_W - 1) : x_q;
        else           x_n = x_q - 1'b1;
      end else if (bus.right && !bus.left) begin
        if (x_q == XW'(GRID_W - 1)) x_n = CURSOR_WRAP ? '0 : x_q;
        else                        x_n = x_q + 1'b1;
      end
      if (bus.up && !bus.down) begin
        if (y_q == '0) y_n = CURSOR_WRAP ? YW'(GRID_H - 1) : y_q;
        else           y_n = y_q - 1'b1;
      end else if (bus.down && !bus.up) begin
        if (y_q == YW'(GRID_H - 1)) y_n = CURSOR_WRAP ? '0 : y_q;
        else                        y_n = y_q + 1'b1;
      end
    end

    case (phase_q)
      SELECT: begin
        if (bus.end_pulse) begin
          phase_n  = ENEMY;
          anim_n   = '0;
          enemy_n  = 1'b1;
          ustate_n = {NUM_UNITS{ST_HIT}};
        end else if (bus.sel_pulse && hit) begin
          phase_n  = ACTION;
          active_n = hit_idx;
          ustate_n[int'(hit_idx)*2 +: 2] = ST_MOVE;
        end
      end
      ACTION: begin
        if (bus.end_pulse) begin
          if (ustate_q[int'(active_q)*2 +: 2] == ST_ATTACK) begin
            phase_n = UNIT_ANIM;
            anim_n  = '0;
          end else begin
            finish = 1'b1;
          end
        end else if (bus.sel_pulse) begin
          ustate_n[int'(active_q)*2 +: 2] =
            (ustate_q[int'(active_q)*2 +: 2] == ST_MOVE) ? ST_ATTACK : ST_MOVE;
        end
      end
      UNIT_ANIM: begin
        if (last_tick)          finish = 1'b1;
        else if (bus.anim_tick) anim_n = anim_q + 1'b1;
      end
      ENEMY: begin
        if (last_tick) begin
          phase_n  = SELECT;
          enemy_n  = 1'b0;
          ustate_n = '1;
          spent_n  = '0;
          anim_n   = '0;
          if (round_q != 8'hFF) round_n = round_q + 1'b1;
        end else if (bus.anim_tick) begin
          anim_n = anim_q + 1'b1;
        end
      end
      default: phase_n = SELECT;
    endcase

    // Unit done: retire it, and hand over to the enemy on the same edge once nobody is left
    if (finish) begin
      ustate_n[int'(active_q)*2 +: 2] = ST_IDLE;
      spent_n = spent_fin;
      anim_n  = '0;
      if (&spent_fin) begin
        phase_n  = ENEMY;
        enemy_n  = 1'b1;
        ustate_n = {NUM_UNITS{ST_HIT}};
      end else begin
        phase_n = SELECT;
      end
    end
  end

  assign bus.cursor_x    = x_q;
  assign bus.cursor_y    = y_q;
  assign bus.cursor_pos  = pos;
  assign bus.phase       = phase_q;
  assign bus.active_unit = active_q;
  assign bus.unit_state  = ustate_q;
  assign bus.spent       = spent_q;
  assign bus.enemy_state = enemy_q;
  assign bus.anim_count  = anim_q;
  assign bus.round_count = round_q;
endmodule
